// File: rtl/line_window_if.sv
// Pixel-stream / 3x3-window bundle between the raster source and the
// window generator. master drives pixels in, slave returns window rows.
//   pix_in/pix_valid/sof    : raster pixel stream, no backpressure
//   A/B/C                   : packed window rows (top, middle, bottom)
//   win_valid/frame_done    : window strobe and last-window pulse
interface line_window_if;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] C;
    logic        win_valid;
    logic        frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  A, B, C, win_valid, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output A, B, C, win_valid, frame_done
    );
endinterface

// File: rtl/line_window_gen.sv
// 3x3 window generator: two line buffers plus three column shift
// registers turn a raster pixel stream into A/B/C window rows.
//   clk, rst_n : clock, async active-low reset
//   bus        : line_window_if.slave (pixels in, window rows out)
module line_window_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    line_window_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [7:0]    lb1_q [IMG_WIDTH];
    logic [7:0]    lb2_q [IMG_WIDTH];

    logic [CW-1:0] col_q, col_d, x;
    logic [RW-1:0] row_q, row_d, y;
    logic [7:0]    top, mid;
    logic [23:0]   top_sr_q, mid_sr_q, bot_sr_q;
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;

    // sof forces the current pixel to (0,0) whatever the counters say
    always_comb begin
        x            = bus.sof ? '0 : col_q;
        y            = bus.sof ? '0 : row_q;
        top          = lb2_q[x];
        mid          = lb1_q[x];
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (bus.pix_valid) begin
            if (x == COL_LAST) begin
                col_d = '0;
                row_d = (y == ROW_LAST) ? '0 : y + RW'(1);
            end else begin
                col_d = x + CW'(1);
                row_d = y;
            end
            // cols 0-1 suppressed so no window straddles a line edge
            win_valid_d  = (y >= RW'(2)) && (x >= CW'(2));
            frame_done_d = (y == ROW_LAST) && (x == COL_LAST);
        end
    end

    // line buffers: read (comb above) before write, no reset
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            lb2_q[x] <= lb1_q[x];
            lb1_q[x] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            top_sr_q     <= '0;
            mid_sr_q     <= '0;
            bot_sr_q     <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            if (bus.pix_valid) begin
                top_sr_q <= {top_sr_q[15:0], top};
                mid_sr_q <= {mid_sr_q[15:0], mid};
                bot_sr_q <= {bot_sr_q[15:0], bus.pix_in};
            end
        end
    end

    assign bus.A          = {8'h00, top_sr_q};
    assign bus.B          = {8'h00, mid_sr_q};
    assign bus.C          = {8'h00, bot_sr_q};
    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen: 4x4 frames on one instance and a
// 512x3 ramp frame on a second instance.
module tb_line_window_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_s;
    logic rst_l;
    int   checks = 0;
    int   fails  = 0;

    line_window_if bs ();
    line_window_if bl ();

    line_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_s (
        .clk(clk), .rst_n(rst_s), .bus(bs.slave)
    );
    line_window_gen #(.IMG_WIDTH(512), .IMG_HEIGHT(3)) u_l (
        .clk(clk), .rst_n(rst_l), .bus(bl.slave)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] pv(int r, int c, bit inv);
        logic [7:0] v;
        v = 8'(16 * r + c);
        return inv ? 8'hFF - v : v;
    endfunction

    // one window row: row r, columns c-2..c
    function automatic logic [31:0] wrow(int r, int c, bit inv);
        return {8'h00, pv(r, c - 2, inv), pv(r, c - 1, inv), pv(r, c, inv)};
    endfunction

    function automatic logic [95:0] wexp(int r, int c, bit inv);
        return {wrow(r - 2, c, inv), wrow(r - 1, c, inv), wrow(r, c, inv)};
    endfunction

    task automatic px_s(input logic [7:0] d, input logic s);
        @(negedge clk);
        bs.pix_in = d; bs.pix_valid = 1'b1; bs.sof = s;
        @(posedge clk); #1;
        bs.pix_valid = 1'b0; bs.sof = 1'b0;
    endtask

    task automatic px_l(input logic [7:0] d, input logic s);
        @(negedge clk);
        bl.pix_in = d; bl.pix_valid = 1'b1; bl.sof = s;
        @(posedge clk); #1;
        bl.pix_valid = 1'b0; bl.sof = 1'b0;
    endtask

    task automatic test_reset;
        rst_s = 1'b0; rst_l = 1'b0;
        bs.pix_in = '0; bs.pix_valid = 1'b0; bs.sof = 1'b0;
        bl.pix_in = '0; bl.pix_valid = 1'b0; bl.sof = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bs.A, bs.B, bs.C} !== 96'h0) begin
            fails++;
            $display("FAIL reset_abc got %h %h %h exp 0", bs.A, bs.B, bs.C);
        end
        checks++;
        if ({bs.win_valid, bs.frame_done, bl.win_valid, bl.frame_done} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags got %b%b exp 00", bs.win_valid, bs.frame_done);
        end
        @(negedge clk);
        rst_s = 1'b1; rst_l = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bs.A, bs.B, bs.C, bs.win_valid} !== 97'h0) begin
            fails++;
            $display("FAIL reset_idle got %h %h %h %b exp 0", bs.A, bs.B, bs.C, bs.win_valid);
        end
    endtask

    task automatic test_frame;
        int nwin = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                px_s(pv(r, c, 0), r == 0 && c == 0);
                checks++;
                if (bs.win_valid !== (r >= 2 && c >= 2)) begin
                    fails++;
                    $display("FAIL frame_wv r=%0d c=%0d got %b", r, c, bs.win_valid);
                end
                checks++;
                if (bs.frame_done !== (r == 3 && c == 3)) begin
                    fails++;
                    $display("FAIL frame_fd r=%0d c=%0d got %b", r, c, bs.frame_done);
                end
                if (bs.win_valid === 1'b1) nwin++;
                if (r >= 2 && c >= 2) begin
                    checks++;
                    if ({bs.A, bs.B, bs.C} !== wexp(r, c, 0)) begin
                        fails++;
                        $display("FAIL frame_abc r=%0d c=%0d got %h %h %h exp %h",
                                 r, c, bs.A, bs.B, bs.C, wexp(r, c, 0));
                    end
                end
                if (r == 2 && c == 2) begin
                    checks++;
                    if ({bs.A, bs.B, bs.C} !== {32'h00000102, 32'h00101112, 32'h00202122}) begin
                        fails++;
                        $display("FAIL frame_first got %h %h %h exp 00000102 00101112 00202122",
                                 bs.A, bs.B, bs.C);
                    end
                end
                if (r == 3 && c == 3) begin
                    checks++;
                    if ({bs.A, bs.B, bs.C} !== {32'h00111213, 32'h00212223, 32'h00313233}) begin
                        fails++;
                        $display("FAIL frame_last got %h %h %h exp 00111213 00212223 00313233",
                                 bs.A, bs.B, bs.C);
                    end
                end
            end
        end
        checks++;
        if (nwin != 4) begin
            fails++;
            $display("FAIL frame_count got %0d exp 4", nwin);
        end
    endtask

    task automatic test_gaps;
        int nwin = 0;
        int k = 0;
        logic [95:0] held;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                px_s(pv(r, c, 0), r == 0 && c == 0);
                k++;
                checks++;
                if (bs.win_valid !== (r >= 2 && c >= 2)) begin
                    fails++;
                    $display("FAIL gap_wv r=%0d c=%0d got %b", r, c, bs.win_valid);
                end
                if (bs.win_valid === 1'b1) begin
                    nwin++;
                    checks++;
                    if ({bs.A, bs.B, bs.C} !== wexp(r, c, 0)) begin
                        fails++;
                        $display("FAIL gap_abc r=%0d c=%0d got %h %h %h exp %h",
                                 r, c, bs.A, bs.B, bs.C, wexp(r, c, 0));
                    end
                end
                held = {bs.A, bs.B, bs.C};
                if (k % 2 == 0) begin
                    for (int g = 0; g < 3; g++) begin
                        @(posedge clk); #1;
                        checks++;
                        if ({bs.win_valid, bs.frame_done} !== 2'b00 ||
                            {bs.A, bs.B, bs.C} !== held) begin
                            fails++;
                            $display("FAIL gap_hold r=%0d c=%0d got %h %b%b exp %h 00",
                                     r, c, {bs.A, bs.B, bs.C}, bs.win_valid,
                                     bs.frame_done, held);
                        end
                    end
                end
            end
        end
        checks++;
        if (nwin != 4) begin
            fails++;
            $display("FAIL gap_count got %0d exp 4", nwin);
        end
    endtask

    task automatic test_back_to_back;
        int nwin = 0;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    px_s(pv(r, c, f == 1), r == 0 && c == 0);
                    if (f == 1) begin
                        checks++;
                        if (bs.win_valid !== (r >= 2 && c >= 2)) begin
                            fails++;
                            $display("FAIL b2b_wv r=%0d c=%0d got %b", r, c, bs.win_valid);
                        end
                        if (bs.win_valid === 1'b1) nwin++;
                        if (r == 2 && c == 2) begin
                            checks++;
                            if ({bs.A, bs.B, bs.C} !==
                                {32'h00FFFEFD, 32'h00EFEEED, 32'h00DFDEDD}) begin
                                fails++;
                                $display("FAIL b2b_first got %h %h %h exp 00FFFEFD 00EFEEED 00DFDEDD",
                                         bs.A, bs.B, bs.C);
                            end
                        end
                    end
                end
            end
        end
        checks++;
        if (nwin != 4) begin
            fails++;
            $display("FAIL b2b_count got %0d exp 4", nwin);
        end
    endtask

    task automatic test_sof_abort;
        int nwin = 0;
        int nfd = 0;
        for (int i = 0; i < 13; i++) begin
            px_s(pv(i / 4, i % 4, 0), i == 0);
            if (bs.frame_done === 1'b1) nfd++;
        end
        checks++;
        if (nfd != 0) begin
            fails++;
            $display("FAIL abort_fd_old got %0d exp 0", nfd);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                px_s(pv(r, c, 0), r == 0 && c == 0);
                checks++;
                if (bs.win_valid !== (r >= 2 && c >= 2) ||
                    bs.frame_done !== (r == 3 && c == 3)) begin
                    fails++;
                    $display("FAIL abort_flags r=%0d c=%0d got %b%b",
                             r, c, bs.win_valid, bs.frame_done);
                end
                if (bs.win_valid === 1'b1) begin
                    nwin++;
                    checks++;
                    if ({bs.A, bs.B, bs.C} !== wexp(r, c, 0)) begin
                        fails++;
                        $display("FAIL abort_abc r=%0d c=%0d got %h %h %h exp %h",
                                 r, c, bs.A, bs.B, bs.C, wexp(r, c, 0));
                    end
                end
            end
        end
        checks++;
        if (nwin != 4) begin
            fails++;
            $display("FAIL abort_count got %0d exp 4", nwin);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 11; i++) px_s(pv(i / 4, i % 4, 0), i == 0);
        checks++;
        if (bs.win_valid !== 1'b1) begin
            fails++;
            $display("FAIL arst_pre got %b exp 1", bs.win_valid);
        end
        @(negedge clk);
        #2;
        rst_s = 1'b0;
        #1;
        checks++;
        if ({bs.A, bs.B, bs.C, bs.win_valid, bs.frame_done} !== 98'h0) begin
            fails++;
            $display("FAIL arst_zero got %h %h %h %b%b exp 0",
                     bs.A, bs.B, bs.C, bs.win_valid, bs.frame_done);
        end
        @(negedge clk);
        rst_s = 1'b1;
        for (int i = 0; i < 16; i++) begin
            px_s(pv(i / 4, i % 4, 0), 1'b0);
            checks++;
            if (bs.win_valid !== (i / 4 >= 2 && i % 4 >= 2)) begin
                fails++;
                $display("FAIL arst_wv i=%0d got %b", i, bs.win_valid);
            end
            if (i == 10) begin
                checks++;
                if ({bs.A, bs.B, bs.C} !== {32'h00000102, 32'h00101112, 32'h00202122}) begin
                    fails++;
                    $display("FAIL arst_first got %h %h %h exp 00000102 00101112 00202122",
                             bs.A, bs.B, bs.C);
                end
            end
        end
    endtask

    task automatic test_ramp_wide;
        int nwin = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 512; c++) begin
                px_l(8'(c), r == 0 && c == 0);
                checks++;
                if (bl.win_valid !== (r == 2 && c >= 2) ||
                    bl.frame_done !== (r == 2 && c == 511)) begin
                    fails++;
                    $display("FAIL ramp_flags r=%0d c=%0d got %b%b",
                             r, c, bl.win_valid, bl.frame_done);
                end
                if (bl.win_valid === 1'b1) nwin++;
                if (r == 2 && c == 257) begin
                    checks++;
                    if ({bl.A, bl.B, bl.C} !== {3{32'h00FF0001}}) begin
                        fails++;
                        $display("FAIL ramp_wrap got %h %h %h exp 00FF0001 x3",
                                 bl.A, bl.B, bl.C);
                    end
                end
            end
        end
        checks++;
        if (nwin != 510) begin
            fails++;
            $display("FAIL ramp_count got %0d exp 510", nwin);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_gaps();
        test_back_to_back();
        test_sof_abort();
        test_async_reset();
        test_ramp_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
